// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: per-channel square wave, half-period strobe and
// full-period strobe at one of four octave-spaced runtime-selectable rates.
module tick_gen_multi #(
    parameter int CLK_HZ = 50_000_000,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 28
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   en,
    input  logic [NUM_CH-1:0]   restart,
    input  logic [2*NUM_CH-1:0] sel,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   period_tick
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLK_HZ) << 1;

    function automatic logic [CNT_W-1:0] term_of(input logic [1:0] s);
        logic [CNT_W-1:0] half;
        case (s)
            2'd0:    half = FULL_CNT;
            2'd1:    half = FULL_CNT >> 1;
            2'd2:    half = FULL_CNT >> 2;
            2'd3:    half = FULL_CNT >> 3;
            default: half = FULL_CNT;
        endcase
        return half - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   clk_q, clk_d;
    logic [NUM_CH-1:0]   tick_q, tick_d;
    logic [NUM_CH-1:0]   ptick_q, ptick_d;
    logic [2*NUM_CH-1:0] sel_q, sel_d;

    // Next-state for every channel: restart/rate change, hold, terminal, count.
    always_comb begin
        sel_d   = sel_q;
        clk_d   = clk_q;
        tick_d  = '0;
        ptick_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (restart[c] || (sel[2*c +: 2] != sel_q[2*c +: 2])) begin
                cnt_d[c]         = '0;
                clk_d[c]         = 1'b0;
                sel_d[2*c +: 2]  = sel[2*c +: 2];
            end else if (!en[c]) begin
                cnt_d[c] = cnt_q[c];
                clk_d[c] = clk_q[c];
            // >= rather than == so a corrupted count can never run past the terminal value
            end else if (cnt_q[c] >= term_of(sel_q[2*c +: 2])) begin
                cnt_d[c]   = '0;
                clk_d[c]   = ~clk_q[c];
                tick_d[c]  = 1'b1;
                ptick_d[c] = ~clk_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    // State registers; reset also captures the current rate selection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
            clk_q   <= '0;
            tick_q  <= '0;
            ptick_q <= '0;
            sel_q   <= sel;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            ptick_q <= ptick_d;
            sel_q   <= sel_d;
        end
    end

    assign clk_out     = clk_q;
    assign tick        = tick_q;
    assign period_tick = ptick_q;

endmodule
